// File: rtl/fifo_drain_ctrl.sv
// Drains batch_len words from a latency-RD_LATENCY FIFO into a credit-controlled skid buffer and
// streams them out over valid/ready with a last-word flag. Optional counters: FIFO_DRAIN_STATS_EN.
module fifo_drain_ctrl #(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 12,
    parameter int RD_LATENCY = 2,
    parameter int BUF_DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  batch_len_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       starve_cnt_o
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    state_t              state;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    issued;
    logic [LEN_W-1:0]    delivered;
    logic [RD_LATENCY-1:0] pipe;
    logic [DATA_W-1:0]   mem [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    occupancy;
    logic [CNT_W-1:0]    inflight;
    logic                pop;
    logic                buf_wr;
    logic                xfer;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe[i]);
        end
    end

    // Words already popped but not yet in the buffer still hold a slot, so the tail write never overflows.
    assign pop          = (state == DRAIN) && !fifo_empty_i && (issued < len) && ((occupancy + inflight) < DEPTH);
    assign fifo_rd_en_o = pop;
    assign buf_wr       = pipe[RD_LATENCY-1];
    assign m_valid_o    = (occupancy != '0);
    assign xfer         = m_valid_o && m_ready_i;
    assign m_data_o     = m_valid_o ? mem[rd_ptr] : '0;
    assign m_last_o     = m_valid_o && (delivered == len - 1'b1);
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (buf_wr) begin
            mem[wr_ptr] <= fifo_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            len       <= '0;
            issued    <= '0;
            delivered <= '0;
            pipe      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            pipe      <= (pipe << 1) | RD_LATENCY'(pop);
            occupancy <= occupancy + CNT_W'(buf_wr) - CNT_W'(xfer);
            if (pop) begin
                issued <= issued + 1'b1;
            end
            if (buf_wr) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (xfer) begin
                rd_ptr    <= bump(rd_ptr);
                delivered <= delivered + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len       <= batch_len_i;
                        issued    <= '0;
                        delivered <= '0;
                        state     <= (batch_len_i == '0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (issued == len) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Leave on the final transfer so done_o follows the last word by one cycle.
                    if (xfer && (delivered == len - 1'b1)) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always @(posedge clk_i) begin
        if (rstn_i) begin
            assert (!(buf_wr && !xfer && (occupancy == DEPTH)));
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_o  <= '0;
            starve_cnt_o <= '0;
        end else if ((state == IDLE) && start_i) begin
            stall_cnt_o  <= '0;
            starve_cnt_o <= '0;
        end else begin
            if (((state == DRAIN) || (state == FLUSH)) && m_valid_o && !m_ready_i
                && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
            if ((state == DRAIN) && fifo_empty_i && (issued < len) && (starve_cnt_o != 16'hFFFF)) begin
                starve_cnt_o <= starve_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule
